// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - parametrised register file with zero register, write bypass, clearing sweep and scoreboard
module regfile_sb #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   ReadRegNum1,
  input  logic [AW-1:0]   ReadRegNum2,
  output logic [XLEN-1:0] ReadRegData1,
  output logic [XLEN-1:0] ReadRegData2,
  input  logic            RegWrite,
  input  logic [AW-1:0]   WriteRegNum,
  input  logic [XLEN-1:0] WriteRegData,
  input  logic            IssueValid,
  input  logic [AW-1:0]   IssueRegNum,
  output logic            Busy1,
  output logic            Busy2,
  output logic            AnyPending,
  output logic            Ready
);

  localparam logic [0:0]    ST_INIT  = 1'b0;
  localparam logic [0:0]    ST_READY = 1'b1;
  localparam logic [AW-1:0] IDX_LAST = AW'(NREGS - 1);

  logic [0:0]      r_state;
  logic [AW-1:0]   r_idx;
  logic [XLEN-1:0] r_regs [NREGS];
  logic [NREGS-1:0] r_pending;

  logic             w_ready;
  logic             w_wr_zero;
  logic             w_iss_zero;
  logic             w_we;
  logic [NREGS-1:0] w_pending_nxt;

  assign w_ready    = (r_state == ST_READY);
  assign w_wr_zero  = (ZERO_REG != 0) && (WriteRegNum == '0);
  assign w_iss_zero = (ZERO_REG != 0) && (IssueRegNum == '0);
  assign w_we       = w_ready && RegWrite && !w_wr_zero;

  // Zero register wins over the bypass; the bypass wins over stored contents.
  function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] num);
    logic [XLEN-1:0] v;
    v = '0;
    if (w_ready && !((ZERO_REG != 0) && (num == '0))) begin
      if (RegWrite && (WriteRegNum == num))
        v = WriteRegData;
      else
        v = r_regs[num];
    end
    return v;
  endfunction

  assign ReadRegData1 = read_port(ReadRegNum1);
  assign ReadRegData2 = read_port(ReadRegNum2);

  // Writeback clears first, then a new issue to the same index re-marks it.
  always_comb begin
    w_pending_nxt = r_pending;
    if (RegWrite)
      w_pending_nxt[WriteRegNum] = 1'b0;
    if (IssueValid && !w_iss_zero)
      w_pending_nxt[IssueRegNum] = 1'b1;
  end

  assign Busy1 = w_ready && r_pending[ReadRegNum1] &&
                 !(RegWrite && (WriteRegNum == ReadRegNum1));
  assign Busy2 = w_ready && r_pending[ReadRegNum2] &&
                 !(RegWrite && (WriteRegNum == ReadRegNum2));
  assign AnyPending = |r_pending;
  assign Ready      = w_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_INIT;
      r_idx     <= '0;
      r_pending <= '0;
    end else begin
      case (r_state)
        ST_INIT: begin
          if (r_idx == IDX_LAST)
            r_state <= ST_READY;
          else
            r_idx <= r_idx + AW'(1);
        end
        default: begin
          r_pending <= w_pending_nxt;
        end
      endcase
    end
  end

  // Contents survive the reset edge itself; the sweep that follows zeroes them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (!w_ready)
        r_regs[r_idx] <= '0;
      else if (w_we)
        r_regs[WriteRegNum] <= WriteRegData;
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - randomized self-checking bench for regfile_sb against a behavioural model
module tb_regfile_sb;
  localparam int NREGS = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ReadRegNum1, ReadRegNum2, WriteRegNum, IssueRegNum;
  logic [31:0] ReadRegData1, ReadRegData2, WriteRegData;
  logic        RegWrite, IssueValid, Busy1, Busy2, AnyPending, Ready;

  int n_vec = 0;
  int n_bad = 0;

  logic [31:0] m_regs [NREGS];
  bit          m_pend [NREGS];
  bit          m_ready;
  int          m_cnt;

  always #5 clk = ~clk;

  regfile_sb dut (
    .clk(clk), .rst(rst),
    .ReadRegNum1(ReadRegNum1), .ReadRegNum2(ReadRegNum2),
    .ReadRegData1(ReadRegData1), .ReadRegData2(ReadRegData2),
    .RegWrite(RegWrite), .WriteRegNum(WriteRegNum), .WriteRegData(WriteRegData),
    .IssueValid(IssueValid), .IssueRegNum(IssueRegNum),
    .Busy1(Busy1), .Busy2(Busy2), .AnyPending(AnyPending), .Ready(Ready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] n);
    if (!m_ready || n == 0) return 32'h0;
    if (RegWrite && WriteRegNum == n) return WriteRegData;
    return m_regs[n];
  endfunction

  function automatic logic exp_busy(input logic [4:0] n);
    return m_ready && m_pend[n] && !(RegWrite && WriteRegNum == n);
  endfunction

  function automatic logic exp_any();
    for (int i = 0; i < NREGS; i++)
      if (m_pend[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive(input logic rs, input logic we, input logic [4:0] wn, input logic [31:0] wd,
                       input logic iv, input logic [4:0] in, input logic [4:0] r1, input logic [4:0] r2);
    rst = rs; RegWrite = we; WriteRegNum = wn; WriteRegData = wd;
    IssueValid = iv; IssueRegNum = in; ReadRegNum1 = r1; ReadRegNum2 = r2;
    #1;
  endtask

  task automatic check_model();
    chk("rd1",   ReadRegData1, exp_rd(ReadRegNum1));
    chk("rd2",   ReadRegData2, exp_rd(ReadRegNum2));
    chk("busy1", {31'b0, Busy1}, {31'b0, exp_busy(ReadRegNum1)});
    chk("busy2", {31'b0, Busy2}, {31'b0, exp_busy(ReadRegNum2)});
    chk("anyp",  {31'b0, AnyPending}, {31'b0, exp_any()});
    chk("ready", {31'b0, Ready}, {31'b0, m_ready});
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_cnt = 0;
      m_ready = 1'b0;
      for (int i = 0; i < NREGS; i++) m_pend[i] = 1'b0;
    end else if (!m_ready) begin
      m_cnt++;
      if (m_cnt == NREGS) begin
        m_ready = 1'b1;
        for (int i = 0; i < NREGS; i++) m_regs[i] = 32'h0;
      end
    end else begin
      if (RegWrite && WriteRegNum != 0) m_regs[WriteRegNum] = WriteRegData;
      if (RegWrite) m_pend[WriteRegNum] = 1'b0;
      if (IssueValid && IssueRegNum != 0) m_pend[IssueRegNum] = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic cyc(input logic rs, input logic we, input logic [4:0] wn, input logic [31:0] wd,
                     input logic iv, input logic [4:0] in, input logic [4:0] r1, input logic [4:0] r2);
    drive(rs, we, wn, wd, iv, in, r1, r2);
    check_model();
    tick();
  endtask

  function automatic logic [4:0] rnd_idx();
    if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 7));
    return 5'($urandom_range(0, 31));
  endfunction

  int first;

  initial begin
    m_ready = 1'b0;
    m_cnt = 0;
    for (int i = 0; i < NREGS; i++) begin m_pend[i] = 1'b0; m_regs[i] = 32'h0; end
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    cyc(1, 0, 0, 0, 0, 0, 3, 4);

    // Sweep latency after reset release.
    first = 0;
    for (int k = 1; k <= 40 && first == 0; k++) begin
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
      if (Ready === 1'b1) first = k;
    end
    chk("rdy_edge", 32'(first), 32'd32);

    for (int i = 0; i < NREGS; i += 2) begin
      drive(0, 0, 0, 0, 0, 0, 5'(i), 5'(i + 1));
      chk("zero_a", ReadRegData1, 32'h0);
      chk("zero_b", ReadRegData2, 32'h0);
      tick();
    end

    drive(0, 1, 5, 32'hDEADBEEF, 0, 0, 5, 0);
    chk("byp5", ReadRegData1, 32'hDEADBEEF);
    check_model(); tick();
    drive(0, 0, 0, 0, 0, 0, 5, 0);
    chk("hold5", ReadRegData1, 32'hDEADBEEF);
    check_model(); tick();

    drive(0, 1, 0, 32'h12345678, 1, 0, 0, 0);
    chk("x0_byp", ReadRegData1, 32'h0);
    check_model(); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("x0_rd", ReadRegData1, 32'h0);
    chk("x0_busy", {31'b0, Busy1}, 32'h0);
    chk("x0_anyp", {31'b0, AnyPending}, 32'h0);
    tick();

    drive(0, 0, 0, 0, 1, 7, 0, 7);
    chk("x7_t0", {31'b0, Busy2}, 32'h0);
    check_model(); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 7);
    chk("x7_t1", {31'b0, Busy2}, 32'h1);
    check_model(); tick();
    cyc(0, 0, 0, 0, 0, 0, 0, 7);
    drive(0, 1, 7, 32'hA5, 0, 0, 0, 7);
    chk("x7_t3b", {31'b0, Busy2}, 32'h0);
    chk("x7_t3d", ReadRegData2, 32'hA5);
    check_model(); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 7);
    chk("x7_t4", {31'b0, AnyPending}, 32'h0);
    check_model(); tick();

    cyc(0, 0, 0, 0, 1, 9, 9, 0);
    cyc(0, 1, 9, 32'hCAFE0009, 1, 9, 9, 0);
    drive(0, 0, 0, 0, 0, 0, 9, 0);
    chk("x9_busy", {31'b0, Busy1}, 32'h1);
    chk("x9_data", ReadRegData1, 32'hCAFE0009);
    check_model(); tick();
    cyc(0, 1, 9, 32'h9, 0, 0, 9, 9);

    // Reset mid-sweep, then writes during the sweep that must not stick.
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 10; k++) cyc(0, 0, 0, 0, 0, 0, 3, 9);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    chk("mid_rst_rdy", {31'b0, Ready}, 32'h0);
    tick();
    first = 0;
    for (int k = 1; k <= 40 && first == 0; k++) begin
      cyc(0, 1, 3, $urandom, 1, 3, 3, 5);
      if (Ready === 1'b1) first = k;
    end
    chk("rdy_edge2", 32'(first), 32'd32);
    drive(0, 0, 0, 0, 0, 0, 3, 5);
    chk("init_wr3", ReadRegData1, 32'h0);
    chk("init_wr5", ReadRegData2, 32'h0);
    chk("init_anyp", {31'b0, AnyPending}, 32'h0);
    tick();

    for (int k = 0; k < 3000; k++)
      cyc(($urandom_range(0, 299) == 0), 1'($urandom_range(0, 1)), rnd_idx(), $urandom,
          1'($urandom_range(0, 1)), rnd_idx(), rnd_idx(), rnd_idx());

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
